// File: rtl/led_bar_pkg.sv
// Shared encodings and sizing helper for the LED-bar decoder.
// Optional feature macro used by the decoder: LED_STEP_CHECK_EN.
package led_bar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RISE  = 2'd1,
        ST_FALL  = 2'd2,
        ST_FLICK = 2'd3
    } state_t;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    function automatic int lvl_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/led_bar_thermo_decode.sv
// Thermometer (from bit 0) to fill-level converter with a legality flag.
// Latency: combinational. Backpressure: none.
// Flow: pure function of led, no handshake.
module thermo_decode
    import led_bar_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int LVL_W = lvl_w(WIDTH)
) (
    input  logic [WIDTH-1:0] led,
    output logic [LVL_W-1:0] level,
    output logic             legal
);

    // A thermometer code plus one is a single power of two, so the AND is zero.
    logic [WIDTH-1:0] led_inc;
    assign led_inc = led + WIDTH'(1);
    assign legal   = ((led & led_inc) == '0);

    always_comb begin
        level = '0;
        for (int i = 0; i < WIDTH; i++) begin
            level = level + LVL_W'(led[i]);
        end
    end

endmodule

// File: rtl/led_bar_decoder.sv
// Decodes the bouncing LED bar to level/direction, counts top hits, auto-flicks at a target level.
// Latency: all outputs registered, one clock after led_in is sampled. Backpressure: none.
// Optional LED_STEP_CHECK_EN: multi-step level jumps also raise pattern_err.
module led_bar_decoder
    import led_bar_pkg::*;
#(
    parameter  int WIDTH        = 16,
    parameter  int TARGET_LEVEL = 6,
    parameter  int FLICK_CYCLES = 4,
    localparam int LVL_W        = lvl_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] led_in,
    input  logic             auto_en,
    output logic             flick_out,
    output logic [LVL_W-1:0] level,
    output logic [1:0]       dir,
    output logic [1:0]       state,
    output logic [7:0]       top_cnt,
    output logic             pattern_err
);

    localparam int CNT_W = (FLICK_CYCLES > 1) ? $clog2(FLICK_CYCLES) : 1;
    localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(WIDTH);
    localparam logic [LVL_W-1:0] LVL_TGT = LVL_W'(TARGET_LEVEL);

    generate
        if (WIDTH < 1 || TARGET_LEVEL < 1 || TARGET_LEVEL > WIDTH || FLICK_CYCLES < 1) begin : g_bad_params
            $error("led_bar_decoder: parameter out of range");
        end
    endgenerate

    logic [LVL_W-1:0] dec_lvl;
    logic             dec_legal;

    thermo_decode #(.WIDTH(WIDTH)) u_decode (
        .led   (led_in),
        .level (dec_lvl),
        .legal (dec_legal)
    );

    state_t           state_q, nxt_state;
    logic [LVL_W-1:0] level_q, nxt_lvl;
    logic [1:0]       dir_q, nxt_dir;
    logic             armed_q, nxt_armed;
    logic [CNT_W-1:0] cnt_q, nxt_cnt;
    logic [7:0]       top_q;
    logic             flick_q, err_q;
    logic             lvl_up, lvl_dn, step_err;

    assign lvl_up = dec_legal && (dec_lvl > level_q);
    assign lvl_dn = dec_legal && (dec_lvl < level_q);

`ifdef LED_STEP_CHECK_EN
    logic [LVL_W:0] new_x, cur_x;
    assign new_x    = {1'b0, dec_lvl};
    assign cur_x    = {1'b0, level_q};
    assign step_err = dec_legal && ((new_x > cur_x + 1'b1) || (cur_x > new_x + 1'b1));
`else
    assign step_err = 1'b0;
`endif

    always_comb begin
        nxt_lvl   = level_q;
        nxt_dir   = dir_q;
        nxt_state = state_q;
        nxt_armed = armed_q;
        nxt_cnt   = cnt_q;

        // Illegal patterns freeze level/dir/state; the flick countdown below still runs.
        if (dec_legal) begin
            nxt_lvl = dec_lvl;
            if (lvl_up) begin
                nxt_dir = DIR_UP;
            end else if (lvl_dn) begin
                nxt_dir = DIR_DOWN;
            end
            if (dec_lvl == '0) begin
                nxt_armed = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (lvl_up) nxt_state = ST_RISE;
            end
            ST_RISE: begin
                if (lvl_dn) begin
                    nxt_state = ST_FALL;
                end else if (lvl_up && dec_lvl == LVL_TGT && auto_en && armed_q) begin
                    nxt_state = ST_FLICK;
                    nxt_armed = 1'b0;
                    nxt_cnt   = CNT_W'(FLICK_CYCLES - 1);
                end
            end
            ST_FALL: begin
                if (dec_legal && dec_lvl == '0) begin
                    nxt_state = ST_IDLE;
                end else if (lvl_up) begin
                    nxt_state = ST_RISE;
                end
            end
            ST_FLICK: begin
                if (cnt_q == '0) begin
                    if (nxt_lvl == '0)          nxt_state = ST_IDLE;
                    else if (nxt_dir == DIR_UP)   nxt_state = ST_RISE;
                    else if (nxt_dir == DIR_DOWN) nxt_state = ST_FALL;
                    else                          nxt_state = ST_IDLE;
                end else begin
                    nxt_cnt = cnt_q - 1'b1;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            dir_q   <= DIR_NONE;
            armed_q <= 1'b1;
            cnt_q   <= '0;
            top_q   <= '0;
            flick_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= nxt_state;
            level_q <= nxt_lvl;
            dir_q   <= nxt_dir;
            armed_q <= nxt_armed;
            cnt_q   <= nxt_cnt;
            flick_q <= (nxt_state == ST_FLICK);
            if (dec_legal && dec_lvl == LVL_TOP && level_q != LVL_TOP && top_q != 8'hFF) begin
                top_q <= top_q + 8'd1;
            end
            if (!dec_legal || step_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign flick_out   = flick_q;
    assign level       = level_q;
    assign dir         = dir_q;
    assign state       = state_q;
    assign top_cnt     = top_q;
    assign pattern_err = err_q;

endmodule

// File: tb/tb_led_bar_decoder.sv
// Directed bench for led_bar_decoder: sweeps, auto-flick, top count saturation, illegal patterns, reset in FLICK.
module tb_led_bar_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] led_in = 16'h0000;
    logic        auto_en = 1'b0;
    logic        flick_out;
    logic [4:0]  level;
    logic [1:0]  dir;
    logic [1:0]  state;
    logic [7:0]  top_cnt;
    logic        pattern_err;

    int n_chk  = 0;
    int n_pass = 0;
    int flick_hi;

    always #5 clk = ~clk;

    led_bar_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .led_in      (led_in),
        .auto_en     (auto_en),
        .flick_out   (flick_out),
        .level       (level),
        .dir         (dir),
        .state       (state),
        .top_cnt     (top_cnt),
        .pattern_err (pattern_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (flick_out) flick_hi++;
    endtask

    function automatic logic [15:0] therm(input int k);
        logic [16:0] t;
        t = (17'd1 << k) - 17'd1;
        return t[15:0];
    endfunction

    // Hold each level for n clocks, from level a to level b (either direction).
    task automatic sweep(input int a, input int b, input int n);
        int s;
        s = (b >= a) ? 1 : -1;
        for (int k = a; k != b + s; k += s) begin
            led_in = therm(k);
            for (int j = 0; j < n; j++) tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        led_in = 16'h0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_level", level, 0);
        chk("rst_dir", dir, 0);
        chk("rst_state", state, 0);
        chk("rst_top", top_cnt, 0);
        chk("rst_flick", flick_out, 0);
        chk("rst_err", pattern_err, 0);

        // Ramp up without auto flick, one step per 4 clocks.
        flick_hi = 0;
        led_in = 16'h0001;
        tick();
        chk("up1_level", level, 1);
        chk("up1_state", state, 1);
        tick(); tick(); tick();
        sweep(2, 16, 4);
        chk("ramp_level", level, 16);
        chk("ramp_dir", dir, 1);
        chk("ramp_state", state, 1);
        chk("ramp_top", top_cnt, 1);
        chk("ramp_noflick", flick_hi, 0);

        led_in = therm(15);
        tick();
        chk("dn1_dir", dir, 2);
        chk("dn1_state", state, 2);
        sweep(14, 0, 1);
        chk("empty_level", level, 0);
        chk("empty_state", state, 0);
        chk("empty_top", top_cnt, 1);

        // Auto flick on the way up.
        auto_en = 1'b1;
        flick_hi = 0;
        sweep(1, 5, 4);
        led_in = 16'h003F;
        tick();
        chk("trig_flick", flick_out, 1);
        chk("trig_state", state, 3);
        chk("trig_level", level, 6);
        auto_en = 1'b0;
        tick(); tick(); tick();
        chk("flick_last", flick_out, 1);
        chk("flick_last_state", state, 3);
        led_in = 16'h007F;
        tick();
        chk("flick_end", flick_out, 0);
        chk("flick_exit_state", state, 1);
        chk("flick_exit_level", level, 7);
        auto_en = 1'b1;
        tick(); tick(); tick();
        sweep(8, 16, 4);
        chk("flick_len", flick_hi, 4);
        chk("top2", top_cnt, 2);

        // Partial fall and re-rise through the target: not re-armed yet.
        flick_hi = 0;
        sweep(15, 3, 1);
        sweep(4, 16, 2);
        chk("no_rearm_flick", flick_hi, 0);
        chk("top3", top_cnt, 3);

        // Empty bar re-arms; next sweep flicks again.
        sweep(15, 0, 1);
        chk("rearm_state", state, 0);
        flick_hi = 0;
        sweep(1, 16, 4);
        chk("rearm_flick", flick_hi, 4);
        chk("top4", top_cnt, 4);

        // Reset during the second cycle of FLICK.
        sweep(15, 0, 1);
        sweep(1, 6, 1);
        chk("rst_trig_state", state, 3);
        tick();
        chk("rst_flick_c2", flick_out, 1);
        reset = 1'b1;
        tick();
        chk("rstf_flick", flick_out, 0);
        chk("rstf_state", state, 0);
        chk("rstf_level", level, 0);
        chk("rstf_top", top_cnt, 0);
        reset = 1'b0;
        auto_en = 1'b0;

        // Illegal pattern mid-sweep.
        do_reset();
        led_in = 16'h0001; tick();
        led_in = 16'h0003; tick();
        led_in = 16'h0007; tick();
        chk("pre_err_level", level, 3);
        led_in = 16'h0005; tick();
        chk("err_set", pattern_err, 1);
        chk("err_level_hold", level, 3);
        chk("err_state_hold", state, 1);
        led_in = 16'h000F; tick();
        chk("err_after_level", level, 4);
        chk("err_sticky", pattern_err, 1);

        // Multi-step jump 2 -> 6.
        do_reset();
        led_in = 16'h0001; tick();
        led_in = 16'h0003; tick();
        chk("step_pre_err", pattern_err, 0);
        led_in = 16'h003F; tick();
        chk("jump_level", level, 6);
`ifdef LED_STEP_CHECK_EN
        chk("jump_err", pattern_err, 1);
`else
        chk("jump_err", pattern_err, 0);
`endif

        // top_cnt saturation with fast 15 <-> 16 toggling.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            led_in = 16'h7FFF; tick();
            led_in = 16'hFFFF; tick();
            if (i == 9) chk("top10", top_cnt, 10);
        end
        chk("top_sat", top_cnt, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
